// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU decoder, alu_exec and mul_seq.
//   - ALUControl operation codes (3 bits).
//   - FSM state encoding for alu_exec.
//   - is_legal_code(): returns 1 for every supported operation code.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Codes 100 and 101 are reserved by the decoder and never legal here.
  function automatic logic is_legal_code(input logic [2:0] code);
    logic legal;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_SUB, ALU_SLT: legal = 1'b1;
      default:                                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier, one iteration per clock.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load operands and begin MUL_ITER iterations
//   op_a, op_b : multiplicand / multiplier, sampled when start=1
//   done       : high during the cycle whose rising edge performs the last
//                iteration; product is valid in that same cycle
//   product    : low WIDTH bits of the unsigned product
module mul_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(MUL_ITER + 1);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sum_s;

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set. Exposed directly so the final step can be
  // captured by the consumer on the same edge it completes.
  always_comb begin
    if (b_r[0]) begin
      sum_s = acc_r + a_r;
    end else begin
      sum_s = acc_r;
    end
  end

  assign product = sum_s;
  assign done    = (cnt_r == CNT_W'(1));

  // Operand capture on start, then iterate until the counter drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      acc_r <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (start) begin
      a_r   <= op_a;
      b_r   <= op_b;
      acc_r <= {WIDTH{1'b0}};
      cnt_r <= CNT_W'(MUL_ITER);
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      acc_r <= sum_s;
      a_r   <= {a_r[WIDTH-2:0], 1'b0};
      b_r   <= {1'b0, b_r[WIDTH-1:1]};
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: valid/ready ALU execution stage.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   ALUControl, SrcA/B   : operation code and operands, captured on accept
//   out_valid / out_ready: result handshake; outputs hold while stalled
//   ALUResult            : registered result
//   Zero                 : ALUResult == 0
//   Illegal              : accepted code was unsupported (result forced 0)
// Single-cycle ops complete on the accepting edge; MUL runs in mul_seq.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal
);

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             illegal_r;

  logic             accept_s;
  logic             mul_start_s;
  logic             slt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_product_s;

  assign accept_s    = in_valid & in_ready_r;
  assign mul_start_s = accept_s & (ALUControl == ALU_MUL);
  assign slt_s       = ($signed(SrcA) < $signed(SrcB));

  // Single-cycle datapath; MUL and illegal codes yield zero here.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    case (ALUControl)
      ALU_ADD: alu_res_s = SrcA + SrcB;
      ALU_SUB: alu_res_s = SrcA - SrcB;
      ALU_AND: alu_res_s = SrcA & SrcB;
      ALU_OR:  alu_res_s = SrcA | SrcB;
      ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  mul_seq #(
    .WIDTH    (WIDTH),
    .MUL_ITER (MUL_ITER)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start_s),
    .op_a    (SrcA),
    .op_b    (SrcB),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      illegal_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            in_ready_r <= 1'b0;
            if (ALUControl == ALU_MUL) begin
              state_r <= S_MUL;
            end else begin
              state_r     <= S_DONE;
              out_valid_r <= 1'b1;
              result_r    <= alu_res_s;
              illegal_r   <= ~is_legal_code(ALUControl);
            end
          end
        end
        S_MUL: begin
          // done is asserted in the cycle of the final iteration, so the
          // product is taken on the same edge that completes it.
          if (mul_done_s) begin
            state_r     <= S_DONE;
            out_valid_r <= 1'b1;
            result_r    <= mul_product_s;
            illegal_r   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign ALUResult = result_r;
  assign Illegal   = illegal_r;
  assign Zero      = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector bench for alu_exec with hand-computed results.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_exec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Illegal;

  int vectors;
  int miscompares;

  alu_exec #(.WIDTH(32), .MUL_ITER(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at the current falling edge, then wait (bounded) for
  // out_valid. Inputs are scrambled right after the accepting edge.
  task automatic do_op(input string tag, input logic [2:0] code,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill,
                       input int exp_lat);
    int  lat;
    bit  busy_bad;
    in_valid   = 1'b1;
    ALUControl = code;
    SrcA       = a;
    SrcB       = b;
    lat        = 0;
    busy_bad   = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid   = 1'b0;
        ALUControl = 3'b011;
        SrcA       = ~a;
        SrcB       = ~b;
      end
      if (!out_valid && in_ready) busy_bad = 1'b1;
    end while (!out_valid && lat < 100);
    check({tag, ".lat"},     32'(lat), 32'(exp_lat));
    check({tag, ".res"},     ALUResult, exp_res);
    check({tag, ".zero"},    {31'd0, Zero}, {31'd0, (exp_res == 32'd0)});
    check({tag, ".illegal"}, {31'd0, Illegal}, {31'd0, exp_ill});
    check({tag, ".busy"},    {31'd0, busy_bad}, 32'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drop"},  {31'd0, out_valid}, 32'd0);
    check({tag, ".ready"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    bit seen_valid;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    ALUControl  = 3'b000;
    SrcA        = 32'd0;
    SrcB        = 32'd0;

    repeat (2) @(negedge clk);
    check("rst.in_ready",  {31'd0, in_ready},  32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.result",    ALUResult,          32'd0);
    check("rst.zero",      {31'd0, Zero},      32'd1);
    check("rst.illegal",   {31'd0, Illegal},   32'd0);

    // First accept on the first rising edge after reset release.
    reset = 1'b0;
    do_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);

    // Backpressure: hold the result for 5 cycles under changing requests.
    for (int i = 0; i < 5; i++) begin
      in_valid   = 1'b1;
      ALUControl = 3'(i);
      SrcA       = 32'(i * 7 + 1);
      SrcB       = 32'(i + 100);
      @(negedge clk);
      check("bp.result", ALUResult,          32'h8000_0000);
      check("bp.valid",  {31'd0, out_valid}, 32'd1);
      check("bp.ready",  {31'd0, in_ready},  32'd0);
      check("bp.zero",   {31'd0, Zero},      32'd0);
    end
    in_valid = 1'b0;
    consume("bp");
    @(negedge clk);
    check("bp.no_accept", {31'd0, out_valid}, 32'd0);

    do_op("sub_eq",  3'b110, 32'd5,          32'd5,          32'd0,          1'b0, 1);
    consume("sub_eq");
    do_op("slt_neg", 3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1);
    consume("slt_neg");
    do_op("slt_pos", 3'b111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1);
    consume("slt_pos");
    do_op("sub_wrap", 3'b110, 32'd0,         32'd1,          32'hFFFF_FFFF,  1'b0, 1);
    consume("sub_wrap");
    do_op("and",     3'b000, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F,  1'b0, 1);
    consume("and");
    do_op("or",      3'b001, 32'h0000_1200,  32'h0000_0034,  32'h0000_1234,  1'b0, 1);
    consume("or");
    do_op("mul",     3'b011, 32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  1'b0, 33);
    consume("mul");
    do_op("mul_max", 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 33);
    consume("mul_max");
    do_op("ill_101", 3'b101, 32'd3,          32'd4,          32'd0,          1'b1, 1);
    consume("ill_101");
    do_op("ill_100", 3'b100, 32'd5,          32'd6,          32'd0,          1'b1, 1);
    consume("ill_100");

    // Reset during a multiply: abort immediately, no late out_valid.
    in_valid   = 1'b1;
    ALUControl = 3'b011;
    SrcA       = 32'd9;
    SrcB       = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort.busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort.in_ready",  {31'd0, in_ready},  32'd1);
    check("abort.out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort.no_pulse", {31'd0, seen_valid}, 32'd0);
    do_op("add_after", 3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    consume("add_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
